// File: rtl/mips_pkg.sv
// Shared constants for the 8-bit multicycle MIPS core:
// opcodes, funct codes, ALU control codes and controller state encodings.
package mips_pkg;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // AOP_NONE parks alucont at 000 in states that do not use the ALU
    typedef enum logic [1:0] {
        AOP_ADD   = 2'b00,
        AOP_SUB   = 2'b01,
        AOP_FUNCT = 2'b10,
        AOP_NONE  = 2'b11
    } aluop_t;

    typedef enum logic [4:0] {
        S_FETCH1  = 5'd0,
        S_FETCH2  = 5'd1,
        S_FETCH3  = 5'd2,
        S_FETCH4  = 5'd3,
        S_DECODE  = 5'd4,
        S_MEMADR  = 5'd5,
        S_LBRD    = 5'd6,
        S_LBWR    = 5'd7,
        S_SBWR    = 5'd8,
        S_RTYPEEX = 5'd9,
        S_RTYPEWR = 5'd10,
        S_BEQEX   = 5'd11,
        S_JEX     = 5'd12,
        S_ADDIEX  = 5'd13,
        S_ADDIWR  = 5'd14,
        S_BNEEX   = 5'd15,
        S_HALT    = 5'd16
    } state_t;

endpackage

// File: rtl/mips_controller_aludec.sv
// ALU decoder: maps the FSM's aluop plus the instruction funct field
// onto the 3-bit ALU control code.
module mips_aludec
    import mips_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alucont
);

    always_comb begin
        o_alucont = ALU_AND;
        case (i_aluop)
            AOP_ADD: o_alucont = ALU_ADD;
            AOP_SUB: o_alucont = ALU_SUB;
            AOP_FUNCT: begin
                case (i_funct)
                    F_SUB:   o_alucont = ALU_SUB;
                    F_AND:   o_alucont = ALU_AND;
                    F_OR:    o_alucont = ALU_OR;
                    F_SLT:   o_alucont = ALU_SLT;
                    default: o_alucont = ALU_ADD;
                endcase
            end
            default: o_alucont = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control FSM for the 8-bit MIPS core.
// Define MIPS_CTRL_BNE_EN to decode BNE (op 000101) into BNEEX.
module mips_controller
    import mips_pkg::*;
#(
    parameter int STATE_W      = 5,
    parameter bit ILLEGAL_HALT = 1'b0
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
    output logic               memread,
    output logic               memwrite,
    output logic               pcen,
    output logic               iord,
    output logic [3:0]         irwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [2:0]         alucont,
    output logic [1:0]         pcsource,
    output logic [STATE_W-1:0] state,
    output logic               halted
);

    state_t      r_state;
    state_t      w_next;
    aluop_t      w_aluop;
    logic        w_memread, w_memwrite, w_pcen, w_iord;
    logic [3:0]  w_irwrite;
    logic        w_regdst, w_memtoreg, w_regwrite, w_alusrca;
    logic [1:0]  w_alusrcb, w_pcsource;
    logic [2:0]  w_alucont;
    logic        w_halted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH1;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next     = S_FETCH1;
        w_aluop    = AOP_NONE;
        w_memread  = 1'b0;
        w_memwrite = 1'b0;
        w_pcen     = 1'b0;
        w_iord     = 1'b0;
        w_irwrite  = 4'b0000;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_pcsource = 2'b00;
        w_halted   = 1'b0;
        case (r_state)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                w_memread = 1'b1;
                w_pcen    = 1'b1;
                w_alusrcb = 2'b01;
                w_aluop   = AOP_ADD;
                w_irwrite = 4'b0001 << r_state[1:0];
                w_next    = (r_state == S_FETCH4) ? S_DECODE
                                                  : state_t'(r_state + 5'd1);
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
                w_aluop   = AOP_ADD;
                case (op)
                    OP_LB, OP_SB: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_RTYPEEX;
                    OP_BEQ:       w_next = S_BEQEX;
                    OP_J:         w_next = S_JEX;
                    OP_ADDI:      w_next = S_ADDIEX;
`ifdef MIPS_CTRL_BNE_EN
                    OP_BNE:       w_next = S_BNEEX;
`endif
                    default:      w_next = ILLEGAL_HALT ? S_HALT : S_FETCH1;
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_aluop   = AOP_ADD;
                if (op == OP_LB)      w_next = S_LBRD;
                else if (op == OP_SB) w_next = S_SBWR;
            end
            S_LBRD: begin
                w_memread = 1'b1;
                w_iord    = 1'b1;
                w_next    = S_LBWR;
            end
            S_LBWR: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
            end
            S_SBWR: begin
                w_memwrite = 1'b1;
                w_iord     = 1'b1;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = AOP_FUNCT;
                w_next    = S_RTYPEWR;
            end
            S_RTYPEWR: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
            end
            S_BEQEX: begin
                w_alusrca  = 1'b1;
                w_aluop    = AOP_SUB;
                w_pcsource = 2'b01;
                w_pcen     = zero;
            end
`ifdef MIPS_CTRL_BNE_EN
            S_BNEEX: begin
                w_alusrca  = 1'b1;
                w_aluop    = AOP_SUB;
                w_pcsource = 2'b01;
                w_pcen     = ~zero;
            end
`endif
            S_JEX: begin
                w_pcsource = 2'b10;
                w_pcen     = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
                w_aluop   = AOP_ADD;
                w_next    = S_ADDIWR;
            end
            S_ADDIWR: w_regwrite = 1'b1;
            S_HALT: begin
                w_halted = 1'b1;
                w_next   = S_HALT;
            end
            default: w_next = S_FETCH1;
        endcase
    end

    mips_aludec u_aludec (
        .i_aluop   (w_aluop),
        .i_funct   (funct),
        .o_alucont (w_alucont)
    );

    // Reset masks everything so nothing leaks out before the first edge
    assign memread  = w_memread  & ~reset;
    assign memwrite = w_memwrite & ~reset;
    assign pcen     = w_pcen     & ~reset;
    assign iord     = w_iord     & ~reset;
    assign irwrite  = reset ? 4'b0000 : w_irwrite;
    assign regdst   = w_regdst   & ~reset;
    assign memtoreg = w_memtoreg & ~reset;
    assign regwrite = w_regwrite & ~reset;
    assign alusrca  = w_alusrca  & ~reset;
    assign alusrcb  = reset ? 2'b00 : w_alusrcb;
    assign alucont  = reset ? 3'b000 : w_alucont;
    assign pcsource = reset ? 2'b00 : w_pcsource;
    assign halted   = w_halted   & ~reset;
    assign state    = STATE_W'(r_state);

endmodule

// File: tb/tb_mips_controller.sv
// Scoreboard bench for mips_controller: per-cycle expected output
// vectors are queued per instruction and compared cycle by cycle.
module tb_mips_controller;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic [5:0] op, funct;
    logic zero;

    logic mr0, mw0, pe0, io0, rd0, mt0, rw0, as0, h0;
    logic mr1, mw1, pe1, io1, rd1, mt1, rw1, as1, h1;
    logic [3:0] ir0, ir1;
    logic [1:0] sb0, sb1, ps0, ps1;
    logic [2:0] ac0, ac1;
    logic [4:0] st0, st1;

    always #5 clk = ~clk;

    mips_controller u_dut0 (
        .clk(clk), .reset(rst0), .op(op), .funct(funct), .zero(zero),
        .memread(mr0), .memwrite(mw0), .pcen(pe0), .iord(io0),
        .irwrite(ir0), .regdst(rd0), .memtoreg(mt0), .regwrite(rw0),
        .alusrca(as0), .alusrcb(sb0), .alucont(ac0), .pcsource(ps0),
        .state(st0), .halted(h0)
    );

    mips_controller #(.ILLEGAL_HALT(1'b1)) u_dut1 (
        .clk(clk), .reset(rst1), .op(op), .funct(funct), .zero(zero),
        .memread(mr1), .memwrite(mw1), .pcen(pe1), .iord(io1),
        .irwrite(ir1), .regdst(rd1), .memtoreg(mt1), .regwrite(rw1),
        .alusrca(as1), .alusrcb(sb1), .alucont(ac1), .pcsource(ps1),
        .state(st1), .halted(h1)
    );

    logic [24:0] v0, v1;
    assign v0 = {st0, mr0, mw0, pe0, io0, ir0, rd0, mt0, rw0,
                 as0, sb0, ac0, ps0, h0};
    assign v1 = {st1, mr1, mw1, pe1, io1, ir1, rd1, mt1, rw1,
                 as1, sb1, ac1, ps1, h1};

    typedef struct {
        string       tag;
        logic [24:0] v;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    logic [5:0] ft[6];
    logic [2:0] fa[6];

    function automatic logic [24:0] mk(
        input logic [4:0] st, input logic mr, mw, pe, io,
        input logic [3:0] ir, input logic rd, mt, rw, as,
        input logic [1:0] sb, input logic [2:0] ac,
        input logic [1:0] ps, input logic h);
        return {st, mr, mw, pe, io, ir, rd, mt, rw, as, sb, ac, ps, h};
    endfunction

    task automatic check(input string tag, input logic [24:0] got,
                         input logic [24:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [24:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        q.push_back(e);
    endtask

    task automatic push_fetch(input string tag);
        for (int i = 0; i < 4; i++)
            push({tag, "_f", $sformatf("%0d", i + 1)},
                 mk(5'(i), 1, 0, 1, 0, 4'(1 << i), 0, 0, 0, 0,
                    2'b01, 3'b010, 2'b00, 0));
        push({tag, "_dec"},
             mk(5'd4, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0,
                2'b11, 3'b010, 2'b00, 0));
    endtask

    task automatic drain(input int which);
        exp_t e;
        while (q.size() > 0) begin
            #1;
            e = q.pop_front();
            check(e.tag, (which == 1) ? v1 : v0, e.v);
            @(negedge clk);
        end
    endtask

    initial begin
        ft = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, 6'b111000};
        fa = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010};
        rst0 = 1'b1;
        rst1 = 1'b1;
        op = OP_RTYPE;
        funct = F_ADD;
        zero = 1'b0;
        @(negedge clk);
        #1 check("rst_hold0", v0, 25'd0);
        check("rst_hold1", v1, 25'd0);
        @(negedge clk);
        rst0 = 1'b0;

        for (int i = 0; i < 6; i++) begin
            op = OP_RTYPE;
            funct = ft[i];
            push_fetch($sformatf("rt%0d", i));
            push($sformatf("rt%0d_ex", i),
                 mk(5'd9, 0, 0, 0, 0, 4'b0, 0, 0, 0, 1,
                    2'b00, fa[i], 2'b00, 0));
            push($sformatf("rt%0d_wr", i),
                 mk(5'd10, 0, 0, 0, 0, 4'b0, 1, 0, 1, 0,
                    2'b00, 3'b000, 2'b00, 0));
            drain(0);
        end

        for (int z = 1; z >= 0; z--) begin
            op = OP_BEQ;
            zero = z[0];
            push_fetch($sformatf("beq%0d", z));
            push($sformatf("beq%0d_ex", z),
                 mk(5'd11, 0, 0, z[0], 0, 4'b0, 0, 0, 0, 1,
                    2'b00, 3'b110, 2'b01, 0));
            drain(0);
        end

        op = OP_LB;
        push_fetch("lb");
        push("lb_adr", mk(5'd5, 0, 0, 0, 0, 4'b0, 0, 0, 0, 1,
                          2'b10, 3'b010, 2'b00, 0));
        push("lb_rd", mk(5'd6, 1, 0, 0, 1, 4'b0, 0, 0, 0, 0,
                         2'b00, 3'b000, 2'b00, 0));
        push("lb_wr", mk(5'd7, 0, 0, 0, 0, 4'b0, 0, 1, 1, 0,
                         2'b00, 3'b000, 2'b00, 0));
        drain(0);

        op = OP_SB;
        push_fetch("sb");
        push("sb_adr", mk(5'd5, 0, 0, 0, 0, 4'b0, 0, 0, 0, 1,
                          2'b10, 3'b010, 2'b00, 0));
        push("sb_wr", mk(5'd8, 0, 1, 0, 1, 4'b0, 0, 0, 0, 0,
                         2'b00, 3'b000, 2'b00, 0));
        drain(0);

        op = OP_ADDI;
        push_fetch("addi");
        push("addi_ex", mk(5'd13, 0, 0, 0, 0, 4'b0, 0, 0, 0, 1,
                           2'b10, 3'b010, 2'b00, 0));
        push("addi_wr", mk(5'd14, 0, 0, 0, 0, 4'b0, 0, 0, 1, 0,
                           2'b00, 3'b000, 2'b00, 0));
        drain(0);

        op = OP_J;
        push_fetch("j");
        push("j_ex", mk(5'd12, 0, 0, 1, 0, 4'b0, 0, 0, 0, 0,
                        2'b00, 3'b000, 2'b10, 0));
        drain(0);

        op = 6'b111111;
        push_fetch("ill");
        drain(0);

        for (int z = 0; z < 2; z++) begin
            op = OP_BNE;
            zero = z[0];
            push_fetch($sformatf("bne%0d", z));
`ifdef MIPS_CTRL_BNE_EN
            push($sformatf("bne%0d_ex", z),
                 mk(5'd15, 0, 0, ~z[0], 0, 4'b0, 0, 0, 0, 1,
                    2'b00, 3'b110, 2'b01, 0));
`endif
            drain(0);
        end

        op = OP_RTYPE;
        funct = F_OR;
        for (int i = 0; i < 4; i++)
            push($sformatf("mid_f%0d", i + 1),
                 mk(5'(i), 1, 0, 1, 0, 4'(1 << i), 0, 0, 0, 0,
                    2'b01, 3'b010, 2'b00, 0));
        push("mid_dec", mk(5'd4, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0,
                           2'b11, 3'b010, 2'b00, 0));
        push("mid_ex", mk(5'd9, 0, 0, 0, 0, 4'b0, 0, 0, 0, 1,
                          2'b00, 3'b001, 2'b00, 0));
        push("mid_wr", mk(5'd10, 0, 0, 0, 0, 4'b0, 1, 0, 1, 0,
                          2'b00, 3'b000, 2'b00, 0));
        drain(0);
        #1 rst0 = 1'b1;
        #1 check("mid_rst", v0, 25'd0);
        @(negedge clk);
        rst0 = 1'b0;
        push("post_f1", mk(5'd0, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0,
                           2'b01, 3'b010, 2'b00, 0));
        drain(0);

        rst0 = 1'b1;
        rst1 = 1'b0;
        op = 6'b111111;
        push_fetch("hlt");
        for (int i = 0; i < 20; i++)
            push($sformatf("hlt_%0d", i),
                 mk(5'd16, 0, 0, 0, 0, 4'b0, 0, 0, 0, 0,
                    2'b00, 3'b000, 2'b00, 1));
        drain(1);
        rst1 = 1'b1;
        #1 check("hlt_rst", v1, 25'd0);
        @(negedge clk);
        rst1 = 1'b0;
        op = OP_J;
        push_fetch("rec");
        push("rec_j", mk(5'd12, 0, 0, 1, 0, 4'b0, 0, 0, 0, 0,
                         2'b00, 3'b000, 2'b10, 0));
        push("rec_f1", mk(5'd0, 1, 0, 1, 0, 4'b0001, 0, 0, 0, 0,
                          2'b01, 3'b010, 2'b00, 0));
        drain(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
